// File: rtl/order_engine.sv
// ---------------------------------------------------------------------------
// order_engine
//
// Purpose:
//   Consumes the trading pipeline stream (signal, allow_trade, kill_switch) and
//   turns the signed Q16.16 signal into discrete BUY/SELL orders. Hysteresis
//   comes from separate entry and exit thresholds. The engine tracks its own
//   position (FLAT/LONG/SHORT/HALTED). A kill request flattens any open
//   position and latches HALTED until clear_halt arrives with a later sample.
//   Each accepted sample that needs an order produces one order in a single
//   output register on a valid/ready stream.
//
// Configuration macro:
//   ORDER_COOLDOWN_EN - when defined, entries are blocked for COOLDOWN cycles
//                       after every order is loaded. When undefined, there is
//                       no counter and only allow_trade gates entries.
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   input sample valid
//   in_ready     out  sample accepted when in_valid && in_ready
//   signal_in    in   signed Q16.16 trading signal
//   allow_trade  in   1 = entries and flips permitted
//   kill_switch  in   1 = flatten and halt
//   clear_halt   in   level; releases HALTED on the next accepted sample
//   out_valid    out  order valid
//   out_ready    in   order consumed when out_valid && out_ready
//   order_side   out  1 = BUY, 0 = SELL
//   order_qty    out  order quantity
//   order_flat   out  1 = kill-induced flatten order
//   pos_state    out  00 FLAT, 01 LONG, 10 SHORT, 11 HALTED
//   order_count  out  number of orders emitted, wraps at 0xFFFF
// ---------------------------------------------------------------------------
module order_engine #(
    parameter logic signed [31:0] ENTRY_TH = 32'sh0000_8000,
    parameter logic signed [31:0] EXIT_TH  = 32'sh0000_2000,
    parameter int                 QTY_W    = 16,
    parameter int                 LOT_SIZE = 100,
    parameter int                 COOLDOWN = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [31:0]      signal_in,
    input  logic                    allow_trade,
    input  logic                    kill_switch,
    input  logic                    clear_halt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    order_side,
    output logic [QTY_W-1:0]        order_qty,
    output logic                    order_flat,
    output logic [1:0]              pos_state,
    output logic [15:0]             order_count
);

    typedef enum logic [1:0] {
        FLAT   = 2'b00,
        LONG   = 2'b01,
        SHORT  = 2'b10,
        HALTED = 2'b11
    } pos_t;

    localparam logic signed [31:0] NEG_ENTRY_TH = -ENTRY_TH;
    localparam logic signed [31:0] NEG_EXIT_TH  = -EXIT_TH;
    localparam logic [QTY_W-1:0]   LOT_QTY      = QTY_W'(LOT_SIZE);
    localparam logic [QTY_W-1:0]   FLIP_QTY     = QTY_W'(2 * LOT_SIZE);

    pos_t             state;
    pos_t             next_state;
    logic             accept;
    logic             make_order;
    logic             load_order;
    logic             next_side;
    logic [QTY_W-1:0] next_qty;
    logic             next_flat;
    logic             entry_ok;

    // A new sample can enter whenever the single output slot is empty or is
    // being drained this cycle, so back-to-back orders leave no bubble.
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign load_order = accept && make_order;
    assign pos_state  = state;

`ifdef ORDER_COOLDOWN_EN
    localparam int CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

    logic [CD_W-1:0] cooldown;

    assign entry_ok = allow_trade && (cooldown == '0);

    // Every loaded order, including exits and flattens, restarts the
    // suppression window. The counter then drains to zero and stops there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cooldown <= '0;
        end else if (load_order) begin
            cooldown <= CD_W'(COOLDOWN);
        end else if (cooldown != '0) begin
            cooldown <= cooldown - CD_W'(1);
        end
    end
`else
    assign entry_ok = allow_trade;
`endif

    // Decision for the sample on the input port. It is evaluated every cycle
    // but takes effect only when the sample is accepted.
    // When entries are blocked, a flip falls through to the plain exit,
    // because a flip-strength signal is always past the exit threshold.
    always_comb begin
        make_order = 1'b0;
        next_side  = 1'b0;
        next_qty   = '0;
        next_flat  = 1'b0;
        next_state = state;

        if (kill_switch) begin
            next_state = HALTED;
            if (state == LONG) begin
                make_order = 1'b1;
                next_side  = 1'b0;
                next_qty   = LOT_QTY;
                next_flat  = 1'b1;
            end else if (state == SHORT) begin
                make_order = 1'b1;
                next_side  = 1'b1;
                next_qty   = LOT_QTY;
                next_flat  = 1'b1;
            end
        end else begin
            case (state)
                HALTED: begin
                    if (clear_halt) begin
                        next_state = FLAT;
                    end
                end
                LONG: begin
                    if (entry_ok && (signal_in < NEG_ENTRY_TH)) begin
                        make_order = 1'b1;
                        next_side  = 1'b0;
                        next_qty   = FLIP_QTY;
                        next_state = SHORT;
                    end else if (signal_in < EXIT_TH) begin
                        make_order = 1'b1;
                        next_side  = 1'b0;
                        next_qty   = LOT_QTY;
                        next_state = FLAT;
                    end
                end
                SHORT: begin
                    if (entry_ok && (signal_in > ENTRY_TH)) begin
                        make_order = 1'b1;
                        next_side  = 1'b1;
                        next_qty   = FLIP_QTY;
                        next_state = LONG;
                    end else if (signal_in > NEG_EXIT_TH) begin
                        make_order = 1'b1;
                        next_side  = 1'b1;
                        next_qty   = LOT_QTY;
                        next_state = FLAT;
                    end
                end
                default: begin
                    if (entry_ok && (signal_in > ENTRY_TH)) begin
                        make_order = 1'b1;
                        next_side  = 1'b1;
                        next_qty   = LOT_QTY;
                        next_state = LONG;
                    end else if (entry_ok && (signal_in < NEG_ENTRY_TH)) begin
                        make_order = 1'b1;
                        next_side  = 1'b0;
                        next_qty   = LOT_QTY;
                        next_state = SHORT;
                    end
                end
            endcase
        end
    end

    // Position state and the output register. The order fields change only
    // when a new order is loaded, so they hold steady while the consumer
    // stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FLAT;
            out_valid   <= 1'b0;
            order_side  <= 1'b0;
            order_qty   <= '0;
            order_flat  <= 1'b0;
            order_count <= 16'd0;
        end else begin
            if (accept) begin
                state <= next_state;
            end
            if (load_order) begin
                out_valid   <= 1'b1;
                order_side  <= next_side;
                order_qty   <= next_qty;
                order_flat  <= next_flat;
                order_count <= order_count + 16'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_order_engine.sv
// ---------------------------------------------------------------------------
// tb_order_engine
//
// Purpose:
//   Self-checking bench for order_engine. A table of directed vectors walks the
//   position machine through entries, exits, flips, threshold edges and the
//   kill/halt path. Hand-written sequences then cover consumer back-pressure,
//   the cooldown window (ORDER_COOLDOWN_EN) and a reset with an order pending.
// ---------------------------------------------------------------------------
module tb_order_engine;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] signal_in;
    logic        allow_trade;
    logic        kill_switch;
    logic        clear_halt;
    logic        out_valid;
    logic        out_ready;
    logic        order_side;
    logic [15:0] order_qty;
    logic        order_flat;
    logic [1:0]  pos_state;
    logic [15:0] order_count;

    int          checks;
    int          errors;
    logic [15:0] exp_count;

    typedef struct {
        logic [31:0] sig;
        logic        allow;
        logic        kill;
        logic        clear;
        logic        exp_valid;
        logic        exp_side;
        logic [15:0] exp_qty;
        logic        exp_flat;
        logic [1:0]  exp_state;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    order_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .signal_in   (signal_in),
        .allow_trade (allow_trade),
        .kill_switch (kill_switch),
        .clear_halt  (clear_halt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .order_side  (order_side),
        .order_qty   (order_qty),
        .order_flat  (order_flat),
        .pos_state   (pos_state),
        .order_count (order_count)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and tally it
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Present one sample for exactly one accepting edge, then return 1 ns
    // after that edge so registered outputs can be sampled
    task automatic applyStimulus(input logic [31:0] sig, input logic allow,
                                 input logic kill, input logic clear);
        @(negedge clk);
        in_valid    = 1'b1;
        signal_in   = sig;
        allow_trade = allow;
        kill_switch = kill;
        clear_halt  = clear;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        kill_switch = 1'b0;
        clear_halt  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic vec_t makeVec(input logic [31:0] sig, input logic allow,
                                     input logic kill, input logic clear,
                                     input logic v, input logic side,
                                     input logic [15:0] qty, input logic flat,
                                     input logic [1:0] st);
        vec_t r;
        r.sig = sig;   r.allow = allow; r.kill = kill;     r.clear = clear;
        r.exp_valid = v; r.exp_side = side; r.exp_qty = qty;
        r.exp_flat = flat; r.exp_state = st;
        return r;
    endfunction

    initial begin
        checks      = 0;
        errors      = 0;
        exp_count   = 16'd0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        signal_in   = 32'h0;
        allow_trade = 1'b1;
        kill_switch = 1'b0;
        clear_halt  = 1'b0;
        out_ready   = 1'b1;

        //                 signal        al kl cl   v  side qty  flat state
        vecs[0]  = makeVec(32'h0000_C000, 1, 0, 0,  1, 1, 16'd100, 0, 2'b01);
        vecs[1]  = makeVec(32'h0000_1000, 1, 0, 0,  1, 0, 16'd100, 0, 2'b00);
        vecs[2]  = makeVec(32'h0000_C000, 1, 0, 0,  1, 1, 16'd100, 0, 2'b01);
        vecs[3]  = makeVec(32'h0000_2000, 1, 0, 0,  0, 0, 16'd0,   0, 2'b01);
        vecs[4]  = makeVec(32'h0000_8000, 1, 0, 0,  0, 0, 16'd0,   0, 2'b01);
        vecs[5]  = makeVec(32'hFFFF_0000, 1, 0, 0,  1, 0, 16'd200, 0, 2'b10);
        vecs[6]  = makeVec(32'h0001_0000, 1, 0, 0,  1, 1, 16'd200, 0, 2'b01);
        vecs[7]  = makeVec(32'hFFFF_0000, 0, 0, 0,  1, 0, 16'd100, 0, 2'b00);
        vecs[8]  = makeVec(32'h0000_8000, 1, 0, 0,  0, 0, 16'd0,   0, 2'b00);
        vecs[9]  = makeVec(32'hFFFF_8000, 1, 0, 0,  0, 0, 16'd0,   0, 2'b00);
        vecs[10] = makeVec(32'hFFFF_4000, 1, 0, 0,  1, 0, 16'd100, 0, 2'b10);
        vecs[11] = makeVec(32'hFFFF_E000, 1, 0, 0,  0, 0, 16'd0,   0, 2'b10);
        vecs[12] = makeVec(32'h0001_0000, 0, 0, 0,  1, 1, 16'd100, 0, 2'b00);
        vecs[13] = makeVec(32'h0000_C000, 0, 0, 0,  0, 0, 16'd0,   0, 2'b00);
        vecs[14] = makeVec(32'hFFFF_4000, 1, 0, 0,  1, 0, 16'd100, 0, 2'b10);
        vecs[15] = makeVec(32'hFFFF_F000, 1, 0, 0,  1, 1, 16'd100, 0, 2'b00);
        vecs[16] = makeVec(32'h0000_C000, 1, 0, 0,  1, 1, 16'd100, 0, 2'b01);
        vecs[17] = makeVec(32'h0000_0000, 1, 1, 0,  1, 0, 16'd100, 1, 2'b11);
        vecs[18] = makeVec(32'h0001_0000, 1, 0, 0,  0, 0, 16'd0,   0, 2'b11);
        vecs[19] = makeVec(32'h0000_0000, 1, 1, 1,  0, 0, 16'd0,   0, 2'b11);
        vecs[20] = makeVec(32'h0000_0000, 1, 0, 1,  0, 0, 16'd0,   0, 2'b00);
        vecs[21] = makeVec(32'h0000_0000, 1, 1, 0,  0, 0, 16'd0,   0, 2'b11);
        vecs[22] = makeVec(32'h0000_C000, 1, 0, 1,  0, 0, 16'd0,   0, 2'b00);
        vecs[23] = makeVec(32'hFFFF_4000, 1, 0, 0,  1, 0, 16'd100, 0, 2'b10);
        vecs[24] = makeVec(32'h0000_0000, 1, 1, 0,  1, 1, 16'd100, 1, 2'b11);
        vecs[25] = makeVec(32'h0000_0000, 1, 0, 1,  0, 0, 16'd0,   0, 2'b00);

        // Reset state
        #12;
        checkOutput("rst_out_valid",   32'(out_valid),   32'd0);
        checkOutput("rst_order_side",  32'(order_side),  32'd0);
        checkOutput("rst_order_qty",   32'(order_qty),   32'd0);
        checkOutput("rst_order_flat",  32'(order_flat),  32'd0);
        checkOutput("rst_pos_state",   32'(pos_state),   32'd0);
        checkOutput("rst_order_count", 32'(order_count), 32'd0);
        checkOutput("rst_in_ready",    32'(in_ready),    32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(2);

        // Table-driven vectors, spaced out so a cooldown window never overlaps
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].sig, vecs[i].allow, vecs[i].kill, vecs[i].clear);
            if (vecs[i].exp_valid) exp_count = exp_count + 16'd1;
            checkOutput($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("v%0d_side", i), 32'(order_side), 32'(vecs[i].exp_side));
                checkOutput($sformatf("v%0d_qty", i),  32'(order_qty),  32'(vecs[i].exp_qty));
                checkOutput($sformatf("v%0d_flat", i), 32'(order_flat), 32'(vecs[i].exp_flat));
            end
            checkOutput($sformatf("v%0d_state", i), 32'(pos_state),   32'(vecs[i].exp_state));
            checkOutput($sformatf("v%0d_count", i), 32'(order_count), 32'(exp_count));
            idleCycles(1);
            checkOutput($sformatf("v%0d_drained", i), 32'(out_valid), 32'd0);
            idleCycles(9);
        end

        // Back-pressure: order held for 5 cycles, then drained while the next
        // sample is accepted on the same edge
        out_ready = 1'b0;
        applyStimulus(32'h0000_C000, 1'b1, 1'b0, 1'b0);
        exp_count = exp_count + 16'd1;
        checkOutput("bp_load_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid  = 1'b1;
        signal_in = 32'h0000_1000;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp%0d_in_ready", k),  32'(in_ready),   32'd0);
            checkOutput($sformatf("bp%0d_valid", k),     32'(out_valid),  32'd1);
            checkOutput($sformatf("bp%0d_side", k),      32'(order_side), 32'd1);
            checkOutput($sformatf("bp%0d_qty", k),       32'(order_qty),  32'd100);
            checkOutput($sformatf("bp%0d_flat", k),      32'(order_flat), 32'd0);
            checkOutput($sformatf("bp%0d_state", k),     32'(pos_state),  32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        exp_count = exp_count + 16'd1;
        checkOutput("bp_next_valid", 32'(out_valid),   32'd1);
        checkOutput("bp_next_side",  32'(order_side),  32'd0);
        checkOutput("bp_next_qty",   32'(order_qty),   32'd100);
        checkOutput("bp_next_state", 32'(pos_state),   32'd0);
        checkOutput("bp_next_count", 32'(order_count), 32'(exp_count));
        idleCycles(1);
        checkOutput("bp_drained", 32'(out_valid), 32'd0);
        idleCycles(9);

        // Cooldown window after an exit order
        applyStimulus(32'h0000_C000, 1'b1, 1'b0, 1'b0);
        exp_count = exp_count + 16'd1;
        checkOutput("cd_entry_state", 32'(pos_state), 32'd1);
        idleCycles(10);
        applyStimulus(32'h0000_1000, 1'b1, 1'b0, 1'b0);
        exp_count = exp_count + 16'd1;
        checkOutput("cd_exit_valid", 32'(out_valid), 32'd1);
        checkOutput("cd_exit_state", 32'(pos_state), 32'd0);
        idleCycles(2);
        applyStimulus(32'h0000_C000, 1'b1, 1'b0, 1'b0);
`ifdef ORDER_COOLDOWN_EN
        checkOutput("cd3_valid", 32'(out_valid),   32'd0);
        checkOutput("cd3_state", 32'(pos_state),   32'd0);
        checkOutput("cd3_count", 32'(order_count), 32'(exp_count));
        idleCycles(5);
        applyStimulus(32'h0000_C000, 1'b1, 1'b0, 1'b0);
        exp_count = exp_count + 16'd1;
        checkOutput("cd9_valid", 32'(out_valid),   32'd1);
        checkOutput("cd9_side",  32'(order_side),  32'd1);
        checkOutput("cd9_qty",   32'(order_qty),   32'd100);
        checkOutput("cd9_state", 32'(pos_state),   32'd1);
        checkOutput("cd9_count", 32'(order_count), 32'(exp_count));
`else
        exp_count = exp_count + 16'd1;
        checkOutput("cd3_valid", 32'(out_valid),   32'd1);
        checkOutput("cd3_side",  32'(order_side),  32'd1);
        checkOutput("cd3_qty",   32'(order_qty),   32'd100);
        checkOutput("cd3_state", 32'(pos_state),   32'd1);
        checkOutput("cd3_count", 32'(order_count), 32'(exp_count));
`endif
        idleCycles(10);

        // Reset while an order is stalled in the output register
        out_ready = 1'b0;
        applyStimulus(32'h0000_1000, 1'b1, 1'b0, 1'b0);
        exp_count = exp_count + 16'd1;
        checkOutput("mid_pending_valid", 32'(out_valid),   32'd1);
        checkOutput("mid_pending_count", 32'(order_count), 32'(exp_count));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(out_valid),   32'd0);
        checkOutput("mid_rst_qty",   32'(order_qty),   32'd0);
        checkOutput("mid_rst_state", 32'(pos_state),   32'd0);
        checkOutput("mid_rst_count", 32'(order_count), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
